// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the multi-outstanding load/store unit.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package riscv_lsu_pkg;

    // Widest destination tag a slot can hold; narrower tags are zero-extended.
    localparam int MaxTagWidth = 8;

    typedef enum logic [1:0] {
        SizeByte   = 2'd0,
        SizeHalf   = 2'd1,
        SizeWord   = 2'd2,
        SizeDouble = 2'd3
    } lsu_size_e;

    // Per-transaction metadata kept from request acceptance until the response pops.
    typedef struct packed {
        logic [MaxTagWidth-1:0] tag;
        lsu_size_e              size;
        logic                   is_signed;
        logic                   we;
        logic [2:0]             offset;
        logic                   err;
    } lsu_slot_t;

    // Byte-enable mask of 2^size bytes starting at byte lane off (8-lane view).
    function automatic logic [7:0] be_gen(input lsu_size_e size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            SizeByte: mask = 8'h01;
            SizeHalf: mask = 8'h03;
            SizeWord: mask = 8'h0F;
            default:  mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

endpackage

// File: rtl/riscv_lsu_multi_outstanding_if.sv
// Bundles the EX request/response channel and the data-memory channel of the LSU.
// Latency: none (wires only).
// Backpressure: qready on the request side, pready on the response side, gnt on memory.
interface riscv_lsu_multi_outstanding_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int TagWidth  = 5
);
    logic                   lsu_qvalid_i;
    logic                   lsu_qready_o;
    logic [AddrWidth-1:0]   lsu_qaddr_i;
    logic                   lsu_qwrite_i;
    logic [1:0]             lsu_qsize_i;
    logic                   lsu_qsigned_i;
    logic [DataWidth-1:0]   lsu_qdata_i;
    logic [TagWidth-1:0]    lsu_qtag_i;
    logic                   lsu_misaligned_o;
    logic                   lsu_pvalid_o;
    logic                   lsu_pready_i;
    logic [DataWidth-1:0]   lsu_pdata_o;
    logic [TagWidth-1:0]    lsu_ptag_o;
    logic                   lsu_pwrite_o;
    logic                   lsu_perror_o;
    logic                   data_req_o;
    logic                   data_gnt_i;
    logic [AddrWidth-1:0]   data_addr_o;
    logic                   data_we_o;
    logic [DataWidth/8-1:0] data_be_o;
    logic [DataWidth-1:0]   data_wdata_o;
    logic                   data_rvalid_i;
    logic [DataWidth-1:0]   data_rdata_i;
    logic                   data_err_i;

    // LSU side
    modport slave (
        input  lsu_qvalid_i, lsu_qaddr_i, lsu_qwrite_i, lsu_qsize_i, lsu_qsigned_i,
               lsu_qdata_i, lsu_qtag_i, lsu_pready_i, data_gnt_i, data_rvalid_i,
               data_rdata_i, data_err_i,
        output lsu_qready_o, lsu_misaligned_o, lsu_pvalid_o, lsu_pdata_o, lsu_ptag_o,
               lsu_pwrite_o, lsu_perror_o, data_req_o, data_addr_o, data_we_o,
               data_be_o, data_wdata_o
    );

    // Environment side (EX stage plus data memory)
    modport master (
        output lsu_qvalid_i, lsu_qaddr_i, lsu_qwrite_i, lsu_qsize_i, lsu_qsigned_i,
               lsu_qdata_i, lsu_qtag_i, lsu_pready_i, data_gnt_i, data_rvalid_i,
               data_rdata_i, data_err_i,
        input  lsu_qready_o, lsu_misaligned_o, lsu_pvalid_o, lsu_pdata_o, lsu_ptag_o,
               lsu_pwrite_o, lsu_perror_o, data_req_o, data_addr_o, data_we_o,
               data_be_o, data_wdata_o
    );
endinterface

// File: rtl/riscv_lsu_rdata_align.sv
// Shifts the bus word down to the access offset, truncates to size and extends.
// Latency: combinational.
// Backpressure: none.
module riscv_lsu_rdata_align
    import riscv_lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] rdata_i,
    input  logic [2:0]           off_i,
    input  lsu_size_e            size_i,
    input  logic                 sign_i,
    output logic [DataWidth-1:0] data_o
);
    localparam int IdxW = $clog2(DataWidth);

    logic [DataWidth-1:0] shifted;
    logic [DataWidth-1:0] keep;
    logic [IdxW-1:0]      msb;
    logic                 ext_bit;

    // Shift, build a keep-mask up to the size MSB, and fill the rest with the extension bit
    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        case (size_i)
            SizeByte: msb = IdxW'(7);
            SizeHalf: msb = IdxW'(15);
            SizeWord: msb = IdxW'(31);
            default:  msb = IdxW'(DataWidth - 1);
        endcase
        keep    = {DataWidth{1'b1}} >> (IdxW'(DataWidth - 1) - msb);
        ext_bit = sign_i & shifted[msb];
        data_o  = (shifted & keep) | ({DataWidth{ext_bit}} & ~keep);
    end

endmodule

// File: rtl/riscv_lsu_multi_outstanding.sv
// Data LSU with up to NumOutstanding in-flight transactions, responses returned in order.
// Latency: request to memory is combinational; response appears one cycle after rvalid.
// Backpressure: request stalls when misaligned, no grant, or all slots are unpopped.
module riscv_lsu_multi_outstanding
    import riscv_lsu_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int NumOutstanding = 4,
    parameter int TagWidth       = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    riscv_lsu_multi_outstanding_if.slave  bus,
    output logic                          busy_o
);
    localparam int OffW  = $clog2(DataWidth / 8);
    localparam int PtrW  = $clog2(NumOutstanding);
    localparam int StrbW = DataWidth / 8;

    logic [PtrW-1:0]           alloc_q, alloc_d, fill_q, fill_d, pop_q, pop_d;
    logic [PtrW:0]             occ_q, occ_d;
    logic [NumOutstanding-1:0] filled_q, filled_d;
    lsu_slot_t                 slot_q  [NumOutstanding];
    lsu_slot_t                 slot_d  [NumOutstanding];
    logic [DataWidth-1:0]      rdata_q [NumOutstanding];
    logic [DataWidth-1:0]      rdata_d [NumOutstanding];

    lsu_size_e            req_size;
    logic [2:0]           req_off;
    logic [2:0]           size_mask;
    logic                 misaligned;
    logic                 req;
    logic                 qready;
    logic                 pvalid;
    logic                 pop;
    lsu_slot_t            cur;
    logic [DataWidth-1:0] aligned;
    logic                 fill_pending;

    // Decode the head request: offset, alignment check and slot availability
    always_comb begin
        req_size = lsu_size_e'(bus.lsu_qsize_i);
        req_off  = 3'(bus.lsu_qaddr_i[OffW-1:0]);
        case (req_size)
            SizeByte: size_mask = 3'b000;
            SizeHalf: size_mask = 3'b001;
            SizeWord: size_mask = 3'b011;
            default:  size_mask = 3'b111;
        endcase
        misaligned = bus.lsu_qvalid_i & (|(req_off & size_mask));
        req        = bus.lsu_qvalid_i & ~misaligned & (occ_q != (PtrW + 1)'(NumOutstanding));
        qready     = req & bus.data_gnt_i;
    end

    assign bus.lsu_misaligned_o = misaligned;
    assign bus.data_req_o       = req;
    assign bus.lsu_qready_o     = qready;
    assign bus.data_addr_o      = req ? {bus.lsu_qaddr_i[AddrWidth-1:OffW], {OffW{1'b0}}} : '0;
    assign bus.data_we_o        = req & bus.lsu_qwrite_i;
    assign bus.data_be_o        = req ? StrbW'(be_gen(req_size, req_off)) : '0;
    assign bus.data_wdata_o     = req ? (bus.lsu_qdata_i << {req_off, 3'b000}) : '0;

    // Pop side: head slot is registered, so pvalid never depends on rvalid this cycle
    assign cur    = slot_q[pop_q];
    assign pvalid = filled_q[pop_q];
    assign pop    = pvalid & bus.lsu_pready_i;

    riscv_lsu_rdata_align #(
        .DataWidth (DataWidth)
    ) u_rdata_align (
        .rdata_i (rdata_q[pop_q]),
        .off_i   (cur.offset),
        .size_i  (cur.size),
        .sign_i  (cur.is_signed),
        .data_o  (aligned)
    );

    assign bus.lsu_pvalid_o = pvalid;
    assign bus.lsu_ptag_o   = pvalid ? TagWidth'(cur.tag) : '0;
    assign bus.lsu_pwrite_o = pvalid & cur.we;
    assign bus.lsu_perror_o = pvalid & cur.err;
    assign bus.lsu_pdata_o  = (pvalid & ~cur.we & ~cur.err) ? aligned : '0;

    assign busy_o = (occ_q != '0) | req;

    // Ring update: allocate on grant, fill on rvalid, retire on pop (any combination per cycle)
    always_comb begin
        alloc_d  = alloc_q;
        fill_d   = fill_q;
        pop_d    = pop_q;
        filled_d = filled_q;
        slot_d   = slot_q;
        rdata_d  = rdata_q;
        if (qready) begin
            slot_d[alloc_q] = '{tag:       MaxTagWidth'(bus.lsu_qtag_i),
                                size:      req_size,
                                is_signed: bus.lsu_qsigned_i,
                                we:        bus.lsu_qwrite_i,
                                offset:    req_off,
                                err:       1'b0};
            alloc_d = alloc_q + PtrW'(1);
        end
        if (pop) begin
            filled_d[pop_q] = 1'b0;
            pop_d           = pop_q + PtrW'(1);
        end
        if (bus.data_rvalid_i) begin
            rdata_d[fill_q]    = bus.data_rdata_i;
            slot_d[fill_q].err = bus.data_err_i;
            filled_d[fill_q]   = 1'b1;
            fill_d             = fill_q + PtrW'(1);
        end
        occ_d = occ_q + (PtrW + 1)'(qready) - (PtrW + 1)'(pop);
    end

    // State registers; reset discards every in-flight slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q  <= '0;
            fill_q   <= '0;
            pop_q    <= '0;
            occ_q    <= '0;
            filled_q <= '0;
            for (int i = 0; i < NumOutstanding; i++) begin
                slot_q[i]  <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            alloc_q  <= alloc_d;
            fill_q   <= fill_d;
            pop_q    <= pop_d;
            occ_q    <= occ_d;
            filled_q <= filled_d;
            slot_q   <= slot_d;
            rdata_q  <= rdata_d;
        end
    end

    // An allocated-but-unfilled slot exists; pointer equality is disambiguated by occupancy
    assign fill_pending = (fill_q != alloc_q) |
                          ((occ_q == (PtrW + 1)'(NumOutstanding)) & ~filled_q[fill_q]);

    a_rvalid_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.data_rvalid_i |-> fill_pending);
    a_no_double_on_32: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.lsu_qvalid_i && (DataWidth == 32) && (bus.lsu_qsize_i == 2'd3)));
    a_addr_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.data_req_o |-> !$isunknown(bus.data_addr_o));

endmodule

// File: tb/tb_riscv_lsu_multi_outstanding.sv
module tb_riscv_lsu_multi_outstanding;
    logic clk_i = 1'b0;
    logic rst_ni;
    logic busy32, busy64;
    int   total = 0;
    int   bad   = 0;

    riscv_lsu_multi_outstanding_if #(.DataWidth(32), .AddrWidth(32), .TagWidth(5)) b ();
    riscv_lsu_multi_outstanding_if #(.DataWidth(64), .AddrWidth(32), .TagWidth(5)) w ();

    riscv_lsu_multi_outstanding #(
        .DataWidth(32), .AddrWidth(32), .NumOutstanding(4), .TagWidth(5)
    ) u32 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (b),
        .busy_o (busy32)
    );

    riscv_lsu_multi_outstanding #(
        .DataWidth(64), .AddrWidth(32), .NumOutstanding(4), .TagWidth(5)
    ) u64 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (w),
        .busy_o (busy64)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request on the 32-bit unit, check it is accepted, and clock it in
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] dat, input logic [4:0] tag,
                         input logic [3:0] exp_be, input string name);
        b.lsu_qvalid_i  = 1'b1;
        b.lsu_qaddr_i   = addr;
        b.lsu_qwrite_i  = wr;
        b.lsu_qsize_i   = sz;
        b.lsu_qsigned_i = sg;
        b.lsu_qdata_i   = dat;
        b.lsu_qtag_i    = tag;
        b.data_gnt_i    = 1'b1;
        #1;
        chk({name, "_qready"}, b.lsu_qready_o, 1);
        chk({name, "_be"}, b.data_be_o, exp_be);
        tick();
    endtask

    task automatic respond(input logic [31:0] d, input logic e);
        b.data_rvalid_i = 1'b1;
        b.data_rdata_i  = d;
        b.data_err_i    = e;
        tick();
        b.data_rvalid_i = 1'b0;
        b.data_err_i    = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [31:0] d, input logic [4:0] tag,
                             input logic e);
        chk({name, "_pvalid"}, b.lsu_pvalid_o, 1);
        chk({name, "_pdata"}, b.lsu_pdata_o, d);
        chk({name, "_ptag"}, b.lsu_ptag_o, tag);
        chk({name, "_perror"}, b.lsu_perror_o, e);
        b.lsu_pready_i = 1'b1;
        tick();
        b.lsu_pready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        b.lsu_qvalid_i = 0; b.lsu_qaddr_i = 0; b.lsu_qwrite_i = 0; b.lsu_qsize_i = 0;
        b.lsu_qsigned_i = 0; b.lsu_qdata_i = 0; b.lsu_qtag_i = 0; b.lsu_pready_i = 0;
        b.data_gnt_i = 0; b.data_rvalid_i = 0; b.data_rdata_i = 0; b.data_err_i = 0;
        w.lsu_qvalid_i = 0; w.lsu_qaddr_i = 0; w.lsu_qwrite_i = 0; w.lsu_qsize_i = 0;
        w.lsu_qsigned_i = 0; w.lsu_qdata_i = 0; w.lsu_qtag_i = 0; w.lsu_pready_i = 0;
        w.data_gnt_i = 0; w.data_rvalid_i = 0; w.data_rdata_i = 0; w.data_err_i = 0;
        #12;
        chk("rst_pvalid", b.lsu_pvalid_o, 0);
        chk("rst_req", b.data_req_o, 0);
        chk("rst_qready", b.lsu_qready_o, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_pdata", b.lsu_pdata_o, 0);
        chk("rst_busy64", busy64, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // LW 0x100, rvalid two cycles after grant
        issue(32'h100, 0, 2'd2, 0, 0, 5'd7, 4'hF, "lw");
        b.lsu_qvalid_i = 0;
        chk("lw_busy", busy32, 1);
        tick();
        b.data_rvalid_i = 1; b.data_rdata_i = 32'hDEADBEEF;
        #1;
        chk("lw_pvalid_with_rvalid", b.lsu_pvalid_o, 0);
        tick();
        b.data_rvalid_i = 0;
        pop_check("lw", 32'hDEADBEEF, 5'd7, 0);
        chk("lw_idle_busy", busy32, 0);

        // Sub-word loads with sign/zero extension
        issue(32'h103, 0, 2'd0, 1, 0, 5'd1, 4'b1000, "lb");
        b.lsu_qvalid_i = 0;
        respond(32'h80FF_FFFF, 0);
        pop_check("lb", 32'hFFFF_FF80, 5'd1, 0);
        issue(32'h102, 0, 2'd1, 0, 0, 5'd2, 4'b1100, "lhu");
        b.lsu_qvalid_i = 0;
        respond(32'h80FF_FFFF, 0);
        pop_check("lhu", 32'h0000_80FF, 5'd2, 0);

        // Fill all four slots, fifth request must wait for a pop
        for (int i = 0; i < 4; i++)
            issue(32'h200 + 32'(4 * i), 0, 2'd2, 0, 0, 5'(10 + i), 4'hF, "bb");
        b.lsu_qaddr_i = 32'h210; b.lsu_qtag_i = 5'd14;
        #1;
        chk("full_qready", b.lsu_qready_o, 0);
        chk("full_req", b.data_req_o, 0);
        chk("full_busy", busy32, 1);
        tick();
        respond(32'h1000, 0);
        chk("full_pop_cycle_qready", b.lsu_qready_o, 0);
        pop_check("bb0", 32'h1000, 5'd10, 0);
        chk("fifth_qready", b.lsu_qready_o, 1);
        tick();

        // Four responses with the consumer stalled for six cycles
        b.lsu_qaddr_i = 32'h300; b.lsu_qtag_i = 5'd15;
        for (int i = 0; i < 4; i++) begin
            respond(32'h1111_1111 * 32'(i + 1), 0);
            chk("stall_req", b.data_req_o, 0);
        end
        tick();
        tick();
        chk("stall_pvalid", b.lsu_pvalid_o, 1);
        chk("stall_qready", b.lsu_qready_o, 0);
        b.lsu_qvalid_i = 0;
        for (int i = 0; i < 4; i++)
            pop_check("stall_pop", 32'h1111_1111 * 32'(i + 1), 5'(11 + i), 0);
        chk("stall_drained_busy", busy32, 0);

        // Misaligned requests are refused without consuming a slot
        b.lsu_qvalid_i = 1; b.lsu_qaddr_i = 32'h102; b.lsu_qsize_i = 2'd2; b.lsu_qwrite_i = 0;
        #1;
        chk("mis_lw_flag", b.lsu_misaligned_o, 1);
        chk("mis_lw_req", b.data_req_o, 0);
        chk("mis_lw_qready", b.lsu_qready_o, 0);
        tick();
        chk("mis_lw_busy", busy32, 0);
        b.lsu_qaddr_i = 32'h101; b.lsu_qsize_i = 2'd1; b.lsu_qwrite_i = 1;
        #1;
        chk("mis_sh_flag", b.lsu_misaligned_o, 1);
        chk("mis_sh_req", b.data_req_o, 0);
        chk("mis_sh_qready", b.lsu_qready_o, 0);
        tick();
        b.lsu_qvalid_i = 0; b.lsu_qwrite_i = 0;
        #1;
        chk("mis_clear_flag", b.lsu_misaligned_o, 0);
        chk("mis_clear_busy", busy32, 0);

        // 64-bit unit: store into upper word, then signed word load from upper word
        w.lsu_qvalid_i = 1; w.lsu_qaddr_i = 32'h104; w.lsu_qwrite_i = 1; w.lsu_qsize_i = 2'd2;
        w.lsu_qdata_i = 64'h1122_3344; w.lsu_qtag_i = 5'd3; w.data_gnt_i = 1;
        #1;
        chk("sw64_be", w.data_be_o, 8'hF0);
        chk("sw64_wdata", w.data_wdata_o, 64'h1122_3344_0000_0000);
        chk("sw64_addr", w.data_addr_o, 32'h100);
        chk("sw64_we", w.data_we_o, 1);
        chk("sw64_qready", w.lsu_qready_o, 1);
        tick();
        w.lsu_qvalid_i = 0; w.data_rvalid_i = 1; w.data_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        w.data_rvalid_i = 0;
        chk("sw64_pvalid", w.lsu_pvalid_o, 1);
        chk("sw64_pwrite", w.lsu_pwrite_o, 1);
        chk("sw64_pdata", w.lsu_pdata_o, 0);
        chk("sw64_ptag", w.lsu_ptag_o, 5'd3);
        w.lsu_pready_i = 1;
        tick();
        w.lsu_pready_i = 0;
        w.lsu_qvalid_i = 1; w.lsu_qwrite_i = 0; w.lsu_qsigned_i = 1; w.lsu_qtag_i = 5'd4;
        #1;
        chk("lw64_be", w.data_be_o, 8'hF0);
        tick();
        w.lsu_qvalid_i = 0; w.data_rvalid_i = 1; w.data_rdata_i = 64'h89AB_CDEF_0000_0000;
        tick();
        w.data_rvalid_i = 0;
        chk("lw64_pdata", w.lsu_pdata_o, 64'hFFFF_FFFF_89AB_CDEF);
        chk("lw64_pwrite", w.lsu_pwrite_o, 0);
        w.lsu_pready_i = 1;
        tick();
        w.lsu_pready_i = 0;
        chk("lw64_busy", busy64, 0);

        // Bus error on the middle of three loads
        issue(32'h400, 0, 2'd2, 0, 0, 5'd20, 4'hF, "e0");
        issue(32'h404, 0, 2'd2, 0, 0, 5'd21, 4'hF, "e1");
        issue(32'h408, 0, 2'd2, 0, 0, 5'd22, 4'hF, "e2");
        b.lsu_qvalid_i = 0;
        respond(32'h0000_000A, 0);
        respond(32'h0000_000B, 1);
        respond(32'h0000_000C, 0);
        pop_check("err0", 32'h0000_000A, 5'd20, 0);
        pop_check("err1", 32'h0, 5'd21, 1);
        pop_check("err2", 32'h0000_000C, 5'd22, 0);

        // Asynchronous reset with transactions in flight
        issue(32'h500, 0, 2'd2, 0, 0, 5'd1, 4'hF, "r0");
        issue(32'h504, 0, 2'd2, 0, 0, 5'd2, 4'hF, "r1");
        b.lsu_qvalid_i = 0;
        respond(32'h55, 0);
        chk("prerst_pvalid", b.lsu_pvalid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_pvalid", b.lsu_pvalid_o, 0);
        chk("midrst_busy", busy32, 0);
        chk("midrst_pdata", b.lsu_pdata_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        issue(32'h600, 0, 2'd2, 0, 0, 5'd9, 4'hF, "post");
        b.lsu_qvalid_i = 0;
        respond(32'h66, 0);
        pop_check("post_rst", 32'h66, 5'd9, 0);
        chk("post_rst_busy", busy32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu_multi_outstanding.md
Name: riscv_lsu_multi_outstanding

Overview:
- Next-generation data LSU: up to NumOutstanding in-flight memory transactions, replacing the single-outstanding Idle/WaitRValid scheme.
- Parametrised data width (32/64); in-order responses through a slot ring buffer; backpressurable writeback port.
- Sits between the EX stage (request channel) and the data memory interface (req/gnt, rvalid).
- Misaligned accesses are detected and refused, not split; the controller traps.

Parameters:
- DataWidth, 32, memory/data width in bits; legal values 32 or 64.
- AddrWidth, 32, address width.
- NumOutstanding, 4, slot count (power of two, >=2).
- TagWidth, 5, opaque destination tag (register index) returned with the response.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- lsu_qvalid_i  in  1  EX request valid
- lsu_qready_o  out  1  request accepted this cycle
- lsu_qaddr_i  in  AddrWidth  byte address
- lsu_qwrite_i  in  1  1=store
- lsu_qsize_i  in  2  0 byte, 1 half, 2 word, 3 double (DataWidth=64 only)
- lsu_qsigned_i  in  1  sign-extend load
- lsu_qdata_i  in  DataWidth  store data, LSB-aligned
- lsu_qtag_i  in  TagWidth  request tag
- lsu_misaligned_o  out  1  head request misaligned (combinational)
- lsu_pvalid_o  out  1  response valid
- lsu_pready_i  in  1  response consumed
- lsu_pdata_o  out  DataWidth  aligned, extended load data (0 for stores)
- lsu_ptag_o  out  TagWidth  tag of the response
- lsu_pwrite_o  out  1  response belongs to a store
- lsu_perror_o  out  1  bus error on this transaction
- data_req_o  out  1  memory request
- data_gnt_i  in  1  grant
- data_addr_o  out  AddrWidth  word/dword-aligned address
- data_we_o  out  1  write enable
- data_be_o  out  DataWidth/8  byte enables
- data_wdata_o  out  DataWidth  shifted write data
- data_rvalid_i  in  1  response valid, never stalled
- data_rdata_i  in  DataWidth  read data
- data_err_i  in  1  error, qualified by data_rvalid_i
- busy_o  out  1  any slot occupied or data_req_o high

Behaviour:
- Reset: all pointers, counts and slot valid/filled flags are 0; all outputs are 0.
- Off = qaddr[log2(DataWidth/8)-1:0]. Misaligned when Off is not a multiple of 2^size.
- Misaligned request: lsu_misaligned_o=1, data_req_o=0, lsu_qready_o=0. No slot is allocated.
- Ring buffer of NumOutstanding slots. Each slot holds tag, size, signed, write, Off, filled, err, rdata.
- Three pointers: alloc, fill, pop. occ counts allocated-not-popped slots, 0..NumOutstanding.
- data_req_o = lsu_qvalid_i & !misaligned & occ<NumOutstanding.
- lsu_qready_o = data_req_o & data_gnt_i.
- On handshake: write metadata into the slot at alloc, then alloc++.
- Memory outputs: data_addr_o = qaddr with offset bits cleared. data_be_o = (2^(2^size)-1) << Off. data_wdata_o = qdata << 8*Off.
- Outputs follow inputs combinationally; the requester must hold them while data_req_o=1 and data_gnt_i=0.
- data_rvalid_i: store rdata_i and err into the slot at fill, set filled, fill++. Responses are in order; rvalid is never dropped.
- Capacity is guaranteed because alloc is gated on occ, which counts unpopped slots.
- lsu_pvalid_o = slot[pop].filled, registered. No combinational rvalid->pvalid path, so minimum load-use latency is rvalid cycle +1.
- lsu_pdata_o = (rdata >> 8*Off), truncated to size, then sign- or zero-extended. Forced to 0 for stores and error responses.
- Pop on pvalid & pready: clear filled, pop++.
- Allocate, fill and pop may all occur in the same cycle. occ next = occ + alloc - pop. Full and pop together still allows the request only in the next cycle (occ is registered).
- Pointers wrap modulo NumOutstanding.
- Asynchronous reset mid-operation discards all slots. The memory side must be reset concurrently.
- Assertions:
  - rvalid with no outstanding unfilled slot is an error.
  - qsize=3 with DataWidth=32 is an error.
  - data_addr_o must not be X while data_req_o=1.

Decomposition:
- Package riscv_lsu_pkg: lsu_size_e enum; lsu_slot_t struct (tag, size, signed, write, offset, err); function be_gen(size, off).
- Sub-module riscv_lsu_rdata_align: combines shift, truncate and extend. It is combinational and parametrised by DataWidth, and is instantiated once on the pop side.

Test Plan:
- DataWidth=32, LW 0x100, gnt immediate, rvalid 2 cycles later with 0xDEADBEEF -> pvalid one cycle after rvalid, pdata=0xDEADBEEF, tag echoed.
- LB signed at 0x103, rdata 0x80FF_FFFF -> be=4'b1000, pdata=0xFFFFFF80. LHU at 0x102, same rdata -> pdata=0x000080FF.
- 4 back-to-back loads, gnt always, rvalid withheld -> 4 accepted, 5th qready=0, busy_o=1. Single rvalid plus pready -> 5th accepted the cycle after the pop.
- pready=0 for 6 cycles while 4 rvalids arrive -> all 4 responses delivered in order, none lost, occ never exceeds 4.
- LW at 0x102 -> misaligned_o=1, data_req_o=0, no slot consumed. SH at 0x101 -> same. SW 0x104 data 0x11223344, DataWidth=64 -> be=8'hF0, wdata upper word 0x11223344.
- rvalid with err=1 on the 2nd of 3 loads -> perror only on the 2nd response, pdata=0. Assert reset mid-flight -> pvalid=0, occ=0, busy_o=0.
